// File: rtl/adc_bank_pkg.sv
// Shared register-map constants for the ADC channel bank.
package adc_bank_pkg;
  // Fixed word addresses; per-channel RANGE words follow the SAMPLE words.
  localparam int STATUS_ADDR = 0;
  localparam int CTRL_ADDR   = 1;
  localparam int SAMPLE_BASE = 2;

  // CTRL register bit positions.
  localparam int CTRL_FREEZE_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // Capture counter width; it occupies STATUS[31:16].
  localparam int COUNT_W = 16;
endpackage

// File: rtl/adc_channel_slice.sv
// One ADC channel: snapshot register, range register and sticky over-range flag.
module adc_channel_slice
  import adc_bank_pkg::*;
#(
  parameter int SAMPLE_W    = 12,
  parameter int RANGE_W     = 8,
  parameter int RANGE_RESET = 'h80
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                capture,
  input  logic                range_we,
  input  logic [RANGE_W-1:0]  range_wdata,
  input  logic                flag_clr,
  output logic [SAMPLE_W-1:0] snapshot,
  output logic [RANGE_W-1:0]  range_q,
  output logic                ovr
);

  // The top RANGE_W bits of the sample are compared with the range value
  // as it stands before any write landing on the same edge.
  logic ovr_hit;
  assign ovr_hit = sample[SAMPLE_W-1 -: RANGE_W] > range_q;

  // Snapshot load, guarded range write, and sticky flag where a new set beats W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      snapshot <= '0;
      range_q  <= RANGE_W'(RANGE_RESET);
      ovr      <= 1'b0;
    end else begin
      if (capture) snapshot <= sample;
      if (range_we && (range_wdata != '0)) range_q <= range_wdata;
      if (capture && ovr_hit) ovr <= 1'b1;
      else if (flag_clr)      ovr <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_channel_bank.sv
// Avalon-MM register bank snapshotting NUM_CH ADC channels coherently.
// Optional feature macro: ADC_IRQ_EN (adds the CTRL.IRQ_EN bit and a registered irq).
module adc_channel_bank
  import adc_bank_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int SAMPLE_W    = 12,
  parameter int RANGE_W     = 8,
  parameter int RANGE_RESET = 'h80,
  parameter int ADDR_W      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*SAMPLE_W-1:0] samples,
  input  logic                       sample_valid,
  output logic [NUM_CH*RANGE_W-1:0]  ranges,
  input  logic [ADDR_W-1:0]          address,
  input  logic                       read,
  output logic [31:0]                readdata,
  input  logic                       write,
  input  logic [31:0]                writedata,
  output logic                       irq
);

  localparam int RANGE_BASE = SAMPLE_BASE + NUM_CH;

  // Bus protocol: no wait states. A read or write is accepted on every edge where
  // read/write is high; readdata holds the word addressed on that edge from the
  // following cycle until the next read. Read and write together both take effect
  // and the read returns the contents before the write.

  logic                freeze;
  logic                irq_en;
  logic                capture;
  logic [COUNT_W-1:0]  count;
  logic [NUM_CH-1:0]   ovr;
  logic [SAMPLE_W-1:0] snap    [NUM_CH];
  logic [RANGE_W-1:0]  range_q [NUM_CH];
  logic                wr_status;
  logic                wr_ctrl;
  logic [31:0]         rd_word;
  logic                unused_wdata;

  assign unused_wdata = ^writedata;
  assign capture   = sample_valid && !freeze;
  assign wr_status = write && (address == ADDR_W'(STATUS_ADDR));
  assign wr_ctrl   = write && (address == ADDR_W'(CTRL_ADDR));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    adc_channel_slice #(
      .SAMPLE_W    (SAMPLE_W),
      .RANGE_W     (RANGE_W),
      .RANGE_RESET (RANGE_RESET)
    ) u_slice (
      .clk         (clk),
      .reset       (reset),
      .sample      (samples[i*SAMPLE_W +: SAMPLE_W]),
      .capture     (capture),
      .range_we    (write && (address == ADDR_W'(RANGE_BASE + i))),
      .range_wdata (writedata[RANGE_W-1:0]),
      .flag_clr    (wr_status && writedata[i]),
      .snapshot    (snap[i]),
      .range_q     (range_q[i]),
      .ovr         (ovr[i])
    );
    assign ranges[i*RANGE_W +: RANGE_W] = range_q[i];
  end

  // CTRL register; IRQ_EN only exists when the interrupt feature is built in.
  always_ff @(posedge clk) begin
    if (reset) begin
      freeze <= 1'b0;
    end else if (wr_ctrl) begin
      freeze <= writedata[CTRL_FREEZE_BIT];
    end
  end

`ifdef ADC_IRQ_EN
  // IRQ_EN bit and level interrupt registered from the current flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= writedata[CTRL_IRQ_EN_BIT];
      irq <= irq_en && (|ovr);
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // Capture counter, wrapping naturally at its width.
  always_ff @(posedge clk) begin
    if (reset)        count <= '0;
    else if (capture) count <= count + 1'b1;
  end

  // Read mux over the register map; unmapped words read zero.
  always_comb begin
    rd_word = '0;
    if (address == ADDR_W'(STATUS_ADDR)) begin
      rd_word[NUM_CH-1:0] = ovr;
      rd_word[31:16]      = count;
    end
    if (address == ADDR_W'(CTRL_ADDR)) begin
      rd_word[CTRL_FREEZE_BIT] = freeze;
      rd_word[CTRL_IRQ_EN_BIT] = irq_en;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (address == ADDR_W'(SAMPLE_BASE + i)) rd_word = 32'(snap[i]);
      if (address == ADDR_W'(RANGE_BASE + i))  rd_word = 32'(range_q[i]);
    end
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (reset)     readdata <= '0;
    else if (read) readdata <= rd_word;
  end

endmodule

// File: tb/tb_adc_channel_bank.sv
// Self-checking bench for adc_channel_bank (default parameters: 2 channels, 12-bit
// samples, 8-bit ranges). Build with +define+ADC_IRQ_EN to exercise the interrupt.
module tb_adc_channel_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] samples;
  logic        sample_valid;
  logic [15:0] ranges;
  logic [3:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

`ifdef ADC_IRQ_EN
  localparam bit IRQ_IMPL = 1'b1;
`else
  localparam bit IRQ_IMPL = 1'b0;
`endif

  // Behavioural model of the register file.
  logic [11:0] m_snap [2];
  logic [7:0]  m_range[2];
  logic [1:0]  m_ovr;
  int          m_count;
  bit          m_freeze, m_irq_en, m_irq;
  logic [31:0] m_rd;

  // Clock and reset block
  always #5 clk = ~clk;

  adc_channel_bank dut (
    .clk(clk), .reset(reset), .samples(samples), .sample_valid(sample_valid),
    .ranges(ranges), .address(address), .read(read), .readdata(readdata),
    .write(write), .writedata(writedata), .irq(irq)
  );

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] w = '0;
    case (a)
      0: w = {16'(m_count), 14'b0, m_ovr};
      1: w = {30'b0, (IRQ_IMPL ? m_irq_en : 1'b0), m_freeze};
      2: w = 32'(m_snap[0]);
      3: w = 32'(m_snap[1]);
      4: w = 32'(m_range[0]);
      5: w = 32'(m_range[1]);
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [23:0] pack(input logic [11:0] c0, input logic [11:0] c1);
    return {c1, c0};
  endfunction

  task automatic model_reset();
    m_snap[0] = '0; m_snap[1] = '0;
    m_range[0] = 8'h80; m_range[1] = 8'h80;
    m_ovr = '0; m_count = 0; m_freeze = 0; m_irq_en = 0; m_irq = 0; m_rd = '0;
  endtask

  // Driver: applies one bus/strobe cycle to DUT and model together.
  task automatic step(input bit sv, input logic [23:0] smp, input bit rd, input bit wr,
                      input int a, input logic [31:0] wd);
    logic [1:0] nov;
    logic [7:0] top;
    sample_valid = sv; samples = smp; read = rd; write = wr;
    address = 4'(a); writedata = wd;
    if (rd) m_rd = m_read(a);
    m_irq = IRQ_IMPL && m_irq_en && (m_ovr != 0);
    nov = m_ovr;
    if (wr && a == 0) nov = nov & ~wd[1:0];
    if (sv && !m_freeze) begin
      for (int ch = 0; ch < 2; ch++) begin
        top = smp[ch*12+4 +: 8];
        if (top > m_range[ch]) nov[ch] = 1'b1;
        m_snap[ch] = smp[ch*12 +: 12];
      end
      m_count = (m_count + 1) % 65536;
    end
    m_ovr = nov;
    if (wr && a == 1) begin
      m_freeze = wd[0];
      m_irq_en = IRQ_IMPL && wd[1];
    end
    if (wr && (a == 4 || a == 5) && wd[7:0] != 0) m_range[a-4] = wd[7:0];
    @(posedge clk); #1;
    sample_valid = 0; read = 0; write = 0;
  endtask

  task automatic test_reset();
    reset = 1; sample_valid = 0; samples = '0; read = 0; write = 0;
    address = '0; writedata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_reset();
    vectors++;
    if (readdata !== 32'h0) begin miscompares++; $display("FAIL reset_readdata got %h want 0", readdata); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
    vectors++;
    if (ranges !== 16'h8080) begin miscompares++; $display("FAIL reset_ranges got %h want 8080", ranges); end
    // Read latency: the address is presented, data appears after the edge.
    address = 4'd4; read = 1;
    #2;
    vectors++;
    if (readdata !== 32'h0) begin miscompares++; $display("FAIL read_latency got %h want 0 before edge", readdata); end
    for (int a = 0; a < 8; a++) begin
      step(0, '0, 1, 0, a, '0);
      vectors++;
      if (readdata !== m_read(a)) begin
        miscompares++; $display("FAIL reset_read_%0d got %h want %h", a, readdata, m_read(a));
      end
    end
  endtask

  task automatic test_capture();
    step(1, pack(12'h123, 12'h0FF), 0, 0, 0, '0);
    step(0, '0, 1, 0, 2, '0);
    vectors++;
    if (readdata !== 32'h123) begin miscompares++; $display("FAIL cap_sample0 got %h want 123", readdata); end
    step(0, '0, 1, 0, 3, '0);
    vectors++;
    if (readdata !== 32'h0FF) begin miscompares++; $display("FAIL cap_sample1 got %h want 0ff", readdata); end
    step(0, '0, 1, 0, 0, '0);
    vectors++;
    if (readdata !== 32'h0001_0000) begin miscompares++; $display("FAIL cap_count got %h want 00010000", readdata); end
  endtask

  task automatic test_freeze();
    step(0, '0, 0, 1, 1, 32'h1);
    step(1, pack(12'h456, 12'h000), 0, 0, 0, '0);
    step(0, '0, 1, 0, 2, '0);
    vectors++;
    if (readdata !== 32'h123) begin miscompares++; $display("FAIL frz_sample0 got %h want 123", readdata); end
    step(0, '0, 1, 0, 0, '0);
    vectors++;
    if (readdata !== 32'h0001_0000) begin miscompares++; $display("FAIL frz_count got %h want 00010000", readdata); end
    step(0, '0, 0, 1, 1, 32'h0);
    step(1, pack(12'h456, 12'h000), 0, 0, 0, '0);
    step(0, '0, 1, 0, 2, '0);
    vectors++;
    if (readdata !== 32'h456) begin miscompares++; $display("FAIL frz_resume got %h want 456", readdata); end
  endtask

  task automatic test_overrange();
    step(0, '0, 0, 1, 4, 32'h10);
    vectors++;
    if (ranges[7:0] !== 8'h10) begin miscompares++; $display("FAIL range_out got %h want 10", ranges[7:0]); end
    step(1, pack(12'h1A0, 12'h010), 0, 0, 0, '0);
    step(0, '0, 1, 0, 0, '0);
    vectors++;
    if (readdata[1:0] !== 2'b01) begin miscompares++; $display("FAIL ovr_set got %b want 01", readdata[1:0]); end
    step(0, '0, 0, 1, 4, 32'h0);
    step(0, '0, 1, 0, 4, '0);
    vectors++;
    if (readdata !== 32'h10) begin miscompares++; $display("FAIL range_zero_write got %h want 10", readdata); end
    // Clear together with a new over-range capture: set wins.
    step(1, pack(12'h1A0, 12'h010), 0, 1, 0, 32'h1);
    step(0, '0, 1, 0, 0, '0);
    vectors++;
    if (readdata[1:0] !== 2'b01) begin miscompares++; $display("FAIL w1c_vs_set got %b want 01", readdata[1:0]); end
    step(0, '0, 0, 1, 0, 32'h1);
    step(0, '0, 1, 0, 0, '0);
    vectors++;
    if (readdata[1:0] !== 2'b00) begin miscompares++; $display("FAIL w1c_clear got %b want 00", readdata[1:0]); end
  endtask

  task automatic test_read_write_same_cycle();
    step(0, '0, 1, 1, 5, 32'h33);
    vectors++;
    if (readdata !== 32'h80) begin miscompares++; $display("FAIL rw_old got %h want 80", readdata); end
    step(0, '0, 1, 0, 5, '0);
    vectors++;
    if (readdata !== 32'h33) begin miscompares++; $display("FAIL rw_new got %h want 33", readdata); end
  endtask

  task automatic test_irq();
    step(0, '0, 0, 1, 1, 32'h2);
    step(1, pack(12'hFF0, 12'h000), 0, 0, 0, '0);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early got %b want 0", irq); end
    step(0, '0, 0, 0, 0, '0);
    vectors++;
    if (irq !== IRQ_IMPL) begin miscompares++; $display("FAIL irq_assert got %b want %b", irq, IRQ_IMPL); end
    step(0, '0, 0, 1, 0, 32'h3);
    step(0, '0, 0, 0, 0, '0);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear got %b want 0", irq); end
    step(0, '0, 0, 1, 1, 32'h0);
  endtask

  task automatic test_random();
    int a;
    for (int n = 0; n < 300; n++) begin
      a = $urandom_range(0, 7);
      step($urandom_range(0, 1), 24'($urandom), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0), a,
           (a == 1) ? 32'($urandom_range(0, 3)) : ($urandom_range(0, 5) == 0 ? 32'h0 : $urandom));
      vectors++;
      if (readdata !== m_rd) begin miscompares++; $display("FAIL rand_readdata got %h want %h", readdata, m_rd); end
      vectors++;
      if (ranges !== {m_range[1], m_range[0]}) begin
        miscompares++; $display("FAIL rand_ranges got %h want %h", ranges, {m_range[1], m_range[0]});
      end
      vectors++;
      if (irq !== m_irq) begin miscompares++; $display("FAIL rand_irq got %b want %b", irq, m_irq); end
    end
  endtask

  task automatic test_count_wrap();
    int budget = 70000;
    step(0, '0, 0, 1, 1, 32'h0);
    while (m_count != 0 && budget > 0) begin
      step(1, 24'($urandom), 0, 0, 0, '0);
      budget--;
    end
    vectors++;
    if (budget == 0) begin miscompares++; $display("FAIL wrap_budget got %0d want 0", m_count); end
    step(0, '0, 1, 0, 0, '0);
    vectors++;
    if (readdata[31:16] !== 16'h0) begin miscompares++; $display("FAIL wrap_count got %h want 0000", readdata[31:16]); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_freeze();
    test_overrange();
    test_read_write_same_cycle();
    test_irq();
    test_random();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
